digitube_hold_scan: RTL and testbench



---
 rtl/digitube_pkg.sv | 28 ++
 rtl/digitube_digit_hold.sv | 67 ++++++
 rtl/digitube_hold_scan.sv | 89 ++++++++
 tb/tb_digitube_hold_scan.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/digitube_pkg.sv
// digitube_pkg: shared helpers for the held digit-tube converter.
`default_nettype none

package digitube_pkg;

  // Decimal point sits on the top segment bit of the default 8-bit bus.
  localparam int DP_BIT = 7;

  function automatic logic [63:0] blank_pat(input int seg_w, input bit active_low);
    return active_low ? ({64{1'b1}} >> (64 - seg_w)) : 64'd0;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

  function automatic int onehot_idx(input logic [31:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digitube_digit_hold.sv
// digitube_digit_hold: one held digit with staleness aging and blanking mux.
`default_nettype none

module digitube_digit_hold
  import digitube_pkg::*;
#(
  parameter int SEG_W          = 8,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT        = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap,
  input  logic [SEG_W-1:0] seg,
  output logic [SEG_W-1:0] seg_out,
  output logic             valid
);

  localparam logic [63:0]      BLANK_FULL = blank_pat(SEG_W, SEG_ACTIVE_LOW);
  localparam logic [SEG_W-1:0] BLANK      = BLANK_FULL[SEG_W-1:0];

  logic [SEG_W-1:0] seg_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_reg <= BLANK;
    end else if (cap) begin
      seg_reg <= seg;
    end
  end

  generate
    if (TIMEOUT > 0) begin : g_age
      localparam int              AW        = $clog2(TIMEOUT + 1);
      localparam logic [AW-1:0]   AGE_MAX   = AW'(TIMEOUT);
      localparam logic [AW-1:0]   AGE_LAST  = AW'(TIMEOUT - 1);
      logic [AW-1:0] age;

      // A capture on this edge takes priority over reaching the timeout.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age   <= '0;
          valid <= 1'b0;
        end else if (cap) begin
          age   <= '0;
          valid <= 1'b1;
        end else if (age < AGE_MAX) begin
          age <= age + 1'b1;
          if (age == AGE_LAST) valid <= 1'b0;
        end
      end
    end else begin : g_no_age
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid <= 1'b0;
        end else if (cap) begin
          valid <= 1'b1;
        end
      end
    end
  endgenerate

  assign seg_out = valid ? seg_reg : BLANK;

endmodule

`default_nettype wire

// File: rtl/digitube_hold_scan.sv
// digitube_hold_scan: samples a scanned tube bus and holds each digit statically.
`default_nettype none

module digitube_hold_scan
  import digitube_pkg::*;
#(
  parameter int N_DIGITS       = 4,
  parameter int SEG_W          = 8,
  parameter bit AN_ACTIVE_LOW  = 1'b0,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter int SETTLE         = 2,
  parameter int TIMEOUT        = 1000000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_DIGITS-1:0]       digi_an,
  input  logic [SEG_W-1:0]          digi_seg,
  output logic [N_DIGITS*SEG_W-1:0] digi_out,
  output logic [N_DIGITS-1:0]       digit_valid,
  output logic                      sel_err,
  output logic                      capture_stb
);

  localparam int             IN_W      = N_DIGITS + SEG_W;
  localparam int             SCW       = $clog2(SETTLE + 1);
  localparam logic [SCW-1:0] SETTLE_C  = SCW'(SETTLE);
  localparam logic [SCW-1:0] SETTLE_M1 = SCW'(SETTLE - 1);

  logic [N_DIGITS-1:0] an_n;
  logic [IN_W-1:0]     in_d;
  logic [IN_W-1:0]     in_q;
  logic [SCW-1:0]      stable_cnt;
  logic                same;
  logic                settled_next;
  logic [N_DIGITS-1:0] an_q;
  logic [SEG_W-1:0]    seg_q;
  logic                an_onehot;
  logic [N_DIGITS-1:0] cap_vec;

  assign an_n         = digi_an ^ {N_DIGITS{AN_ACTIVE_LOW}};
  assign in_d         = {an_n, digi_seg};
  assign same         = (in_d == in_q);
  assign settled_next = same && (stable_cnt >= SETTLE_M1);
  assign an_q         = in_q[IN_W-1 -: N_DIGITS];
  assign seg_q        = in_q[SEG_W-1:0];
  assign an_onehot    = is_onehot(32'(an_q));
  assign cap_vec      = (settled_next && an_onehot) ? an_q : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_q        <= '0;
      stable_cnt  <= '0;
      sel_err     <= 1'b0;
      capture_stb <= 1'b0;
    end else begin
      in_q <= in_d;
      if (!same) begin
        stable_cnt <= '0;
      end else if (stable_cnt < SETTLE_C) begin
        stable_cnt <= stable_cnt + 1'b1;
      end
      capture_stb <= settled_next && an_onehot;
      // Error flag only re-evaluates on a settled input; glitches leave it alone.
      if (settled_next) begin
        sel_err <= (an_q != '0) && !an_onehot;
      end
    end
  end

  generate
    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
      digitube_digit_hold #(
        .SEG_W         (SEG_W),
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW),
        .TIMEOUT       (TIMEOUT)
      ) u_hold (
        .clk    (clk),
        .rst_n  (rst_n),
        .cap    (cap_vec[i]),
        .seg    (seg_q),
        .seg_out(digi_out[i*SEG_W +: SEG_W]),
        .valid  (digit_valid[i])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_digitube_hold_scan.sv
// tb_digitube_hold_scan: directed scoreboard bench for the held tube converter.
`default_nettype none

module tb_digitube_hold_scan;

  localparam int N  = 4;
  localparam int SW = 7;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    digi_an;
  logic [SW-1:0]   digi_seg;
  logic [N*SW-1:0] digi_out;
  logic [N-1:0]    digit_valid;
  logic            sel_err;
  logic            capture_stb;

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  digitube_hold_scan #(
    .N_DIGITS      (N),
    .SEG_W         (SW),
    .AN_ACTIVE_LOW (1'b0),
    .SEG_ACTIVE_LOW(1'b1),
    .SETTLE        (2),
    .TIMEOUT       (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .digi_an    (digi_an),
    .digi_seg   (digi_seg),
    .digi_out   (digi_out),
    .digit_valid(digit_valid),
    .sel_err    (sel_err),
    .capture_stb(capture_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sbq.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL sb_empty: observed %h required an entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pack4(input logic [6:0] d3, input logic [6:0] d2,
                                        input logic [6:0] d1, input logic [6:0] d0);
    return 64'({d3, d2, d1, d0});
  endfunction

  localparam logic [6:0] BL = 7'h7F;

  initial begin
    logic [6:0] rr_seg [4];
    rr_seg[0] = 7'h40; rr_seg[1] = 7'h79; rr_seg[2] = 7'h24; rr_seg[3] = 7'h30;

    // Reset state
    rst_n = 1'b0; digi_an = '0; digi_seg = '0;
    push("rst_out", pack4(BL, BL, BL, BL));
    push("rst_valid", 64'h0);
    push("rst_selerr", 64'h0);
    push("rst_stb", 64'h0);
    tick(3);
    chk(64'(digi_out)); chk(64'(digit_valid)); chk(64'(sel_err)); chk(64'(capture_stb));

    // Latency: value before E0 appears after E2
    rst_n = 1'b1;
    digi_an = 4'b0001; digi_seg = 7'h40;
    push("lat_stb_e0", 64'h0); push("lat_stb_e1", 64'h0); push("lat_valid_e1", 64'h0);
    push("lat_stb_e2", 64'h1); push("lat_valid_e2", 64'h1);
    push("lat_out_e2", pack4(BL, BL, BL, 7'h40));
    tick(1); chk(64'(capture_stb));
    tick(1); chk(64'(capture_stb)); chk(64'(digit_valid));
    tick(1); chk(64'(capture_stb)); chk(64'(digit_valid)); chk(64'(digi_out));

    // Glitch: 2-edge pulse on digit 2 must never be captured
    digi_an = 4'b0100; digi_seg = 7'h24;
    push("gl_stb_a", 64'h0); push("gl_stb_b", 64'h0);
    tick(1); chk(64'(capture_stb));
    tick(1); chk(64'(capture_stb));
    digi_an = 4'b0001; digi_seg = 7'h40;
    push("gl_stb_c", 64'h0); push("gl_stb_d", 64'h0); push("gl_stb_e", 64'h1);
    push("gl_valid", 64'h1); push("gl_out", pack4(BL, BL, BL, 7'h40));
    tick(1); chk(64'(capture_stb));
    tick(1); chk(64'(capture_stb));
    tick(1); chk(64'(capture_stb)); chk(64'(digit_valid)); chk(64'(digi_out));

    // Multi-select raises sel_err without touching any slice
    digi_an = 4'b0011; digi_seg = 7'h00;
    push("ms_err_early", 64'h0); push("ms_err", 64'h1); push("ms_stb", 64'h0);
    push("ms_out", pack4(BL, BL, BL, 7'h40)); push("ms_valid", 64'h1);
    tick(2); chk(64'(sel_err));
    tick(1); chk(64'(sel_err)); chk(64'(capture_stb)); chk(64'(digi_out)); chk(64'(digit_valid));
    digi_an = 4'b0000;
    push("ms_err_hold", 64'h1); push("ms_err_clr", 64'h0); push("ms_out_after", pack4(BL, BL, BL, 7'h40));
    tick(2); chk(64'(sel_err));
    tick(1); chk(64'(sel_err)); chk(64'(digi_out));

    // Round-robin scan, 4 edges per digit
    for (int i = 0; i < 4; i++) begin
      digi_an = 4'(1 << i); digi_seg = rr_seg[i];
      tick(4);
    end
    push("rr_valid", 64'hF);
    push("rr_out", pack4(7'h30, 7'h24, 7'h79, 7'h40));
    chk(64'(digit_valid)); chk(64'(digi_out));

    // Timeout: digit 0 blanks on the 16th edge after its last capture
    digi_an = 4'b0001; digi_seg = 7'h40;
    push("to_cap_stb", 64'h1);
    tick(3); chk(64'(capture_stb));
    digi_an = 4'b0010; digi_seg = 7'h79;
    push("to_valid_e15", 64'h3); push("to_d0_e15", 64'h40);
    push("to_valid_e16", 64'h2); push("to_out_e16", pack4(BL, BL, 7'h79, BL));
    tick(15); chk(64'(digit_valid)); chk(64'(digi_out[6:0]));
    tick(1);  chk(64'(digit_valid)); chk(64'(digi_out));

    // Asynchronous reset mid-run, then full settle after release
    #1 rst_n = 1'b0;
    push("ar_out", pack4(BL, BL, BL, BL)); push("ar_valid", 64'h0); push("ar_err", 64'h0);
    #1 chk(64'(digi_out)); chk(64'(digit_valid)); chk(64'(sel_err));
    #1 rst_n = 1'b1;
    push("ar_stb_e0", 64'h0); push("ar_stb_e1", 64'h0); push("ar_valid_e1", 64'h0);
    push("ar_stb_e2", 64'h1); push("ar_out_e2", pack4(BL, BL, 7'h79, BL));
    tick(1); chk(64'(capture_stb));
    tick(1); chk(64'(capture_stb)); chk(64'(digit_valid));
    tick(1); chk(64'(capture_stb)); chk(64'(digi_out));

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $error("FAIL sb_leftover: observed %0d entries expected 0", sbq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
